// File: rtl/ama_riscv_hazard_ctrl_pkg.sv
// ama_riscv_hazard_ctrl_pkg: shared FSM encoding and register-file constants for the hazard controller
package ama_riscv_hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    RESET    = 2'd0,
    RUN      = 2'd1,
    FLUSH2   = 2'd2,
    MEM_WAIT = 2'd3
  } hz_state_t;
  localparam logic [4:0] RF_X0_ZERO = 5'd0;
endpackage

// File: rtl/ama_riscv_sat_counter.sv
// ama_riscv_sat_counter: event counter that sticks at all-ones instead of wrapping
module ama_riscv_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  // count up on inc until every bit is set
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/ama_riscv_hazard_ctrl.sv
// ama_riscv_hazard_ctrl: load-use / taken-branch / DMEM-wait pipeline control with stall and flush counters
module ama_riscv_hazard_ctrl
  import ama_riscv_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [4:0]       rd_ex,
  input  logic             reg_we_ex,
  input  logic             load_inst_ex,
  input  logic             load_inst_mem,
  input  logic             branch_taken_ex,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_clear,
  output logic             id_ex_we,
  output logic             id_ex_clear,
  output logic             ex_mem_we,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  hz_state_t state, state_nxt;
  logic load_use, mem_wait, rst_st, frz, flush, stall;
  assign load_use = load_inst_ex && reg_we_ex && rd_ex != RF_X0_ZERO &&
                    ((rs1_used_id && rs1_id == rd_ex) || (rs2_used_id && rs2_id == rd_ex));
  assign mem_wait = load_inst_mem && !dmem_ready;
  assign rst_st   = state == RESET;
  // freeze wins over everything; a pending branch waits in EX until DMEM answers
  assign frz   = !rst_st && (mem_wait || (state == MEM_WAIT && !dmem_ready));
  assign flush = !rst_st && !frz && branch_taken_ex;
  assign stall = !rst_st && !frz && !flush && load_use;
  assign pc_we       = !rst_st && !frz && !stall;
  assign if_id_we    = pc_we;
  assign id_ex_we    = !rst_st && !frz;
  assign ex_mem_we   = id_ex_we;
  // FLUSH2 squashes the one wrong-path fetch still in flight from IMEM
  assign if_id_clear = rst_st || flush || (state == FLUSH2 && !frz);
  assign id_ex_clear = rst_st || flush || stall;
  // next-state selection
  always_comb
    state_nxt = frz ? MEM_WAIT : flush ? FLUSH2 : RUN;
  // state register; RESET is left on the first edge after rst_n rises
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RESET;
    else state <= state_nxt;
  ama_riscv_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!rst_st && !pc_we),
    .cnt   (stall_cnt)
  );
  ama_riscv_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush),
    .cnt   (flush_cnt)
  );
endmodule

// File: tb/tb_ama_riscv_hazard_ctrl.sv
// tb_ama_riscv_hazard_ctrl: directed scoreboard bench for the hazard controller (32-bit and 4-bit counter instances)
module tb_ama_riscv_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic rs1_used_id, rs2_used_id, reg_we_ex, load_inst_ex, load_inst_mem, branch_taken_ex, dmem_ready;
  logic pc_we, if_id_we, if_id_clear, id_ex_we, id_ex_clear, ex_mem_we;
  logic pc_we4, if_id_we4, if_id_clear4, id_ex_we4, id_ex_clear4, ex_mem_we4;
  logic [31:0] stall_cnt, flush_cnt;
  logic [3:0] stall_cnt4, flush_cnt4;

  ama_riscv_hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .rd_ex(rd_ex),
    .reg_we_ex(reg_we_ex), .load_inst_ex(load_inst_ex), .load_inst_mem(load_inst_mem),
    .branch_taken_ex(branch_taken_ex), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_clear(if_id_clear),
    .id_ex_we(id_ex_we), .id_ex_clear(id_ex_clear), .ex_mem_we(ex_mem_we),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  ama_riscv_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id), .rd_ex(rd_ex),
    .reg_we_ex(reg_we_ex), .load_inst_ex(load_inst_ex), .load_inst_mem(load_inst_mem),
    .branch_taken_ex(branch_taken_ex), .dmem_ready(dmem_ready),
    .pc_we(pc_we4), .if_id_we(if_id_we4), .if_id_clear(if_id_clear4),
    .id_ex_we(id_ex_we4), .id_ex_clear(id_ex_clear4), .ex_mem_we(ex_mem_we4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  always #5 clk = ~clk;

  // {pc_we, if_id_we, if_id_clear, id_ex_we, id_ex_clear, ex_mem_we}
  localparam logic [5:0] NORM  = 6'b110101;
  localparam logic [5:0] FRZ   = 6'b000000;
  localparam logic [5:0] FLUSH = 6'b111111;
  localparam logic [5:0] FL2   = 6'b111101;
  localparam logic [5:0] LU    = 6'b000111;
  localparam logic [5:0] RST   = 6'b001010;
  // {rs1_used, rs2_used, reg_we_ex, load_ex, load_mem, branch, dmem_ready}
  localparam logic [6:0] IDLE  = 7'b0000001;
  localparam logic [6:0] LDUSE = 7'b1111001;
  localparam logic [6:0] BR    = 7'b0000011;
  localparam logic [6:0] MISS  = 7'b0000100;
  localparam logic [6:0] HIT   = 7'b0000101;

  typedef struct {
    logic [5:0] o;
    int sc;
    int fc;
  } exp_t;

  exp_t q[$];
  int vec = 0, mis = 0, sc_m = 0, fc_m = 0, stepn = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s step %0d observed %0h expected %0h", tag, stepn, obs, exp);
    end
  endtask

  task automatic cyc(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                     input logic [6:0] f, input logic rs, input logic [5:0] eo);
    exp_t e;
    rs1_id = a;
    rs2_id = b;
    rd_ex  = d;
    {rs1_used_id, rs2_used_id, reg_we_ex, load_inst_ex, load_inst_mem, branch_taken_ex, dmem_ready} = f;
    if (!rst_n) begin
      sc_m = 0;
      fc_m = 0;
    end
    q.push_back('{eo, sc_m, fc_m});
    @(negedge clk);
    e = q.pop_front();
    stepn++;
    chk("ctrl", {26'd0, pc_we, if_id_we, if_id_clear, id_ex_we, id_ex_clear, ex_mem_we}, {26'd0, e.o});
    chk("stall_cnt", stall_cnt, e.sc);
    chk("flush_cnt", flush_cnt, e.fc);
    chk("stall_cnt4", {28'd0, stall_cnt4}, (e.sc > 15) ? 32'd15 : e.sc);
    chk("flush_cnt4", {28'd0, flush_cnt4}, (e.fc > 15) ? 32'd15 : e.fc);
    if (!rs && !eo[5]) sc_m++;
    if (eo == FLUSH) fc_m++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {rs1_id, rs2_id, rd_ex} = '0;
    {rs1_used_id, rs2_used_id, reg_we_ex, load_inst_ex, load_inst_mem, branch_taken_ex, dmem_ready} = IDLE;
    @(posedge clk);
    #1;
    repeat (3) cyc(0, 0, 0, IDLE, 1, RST);
    rst_n = 1'b1;
    cyc(0, 0, 0, IDLE, 1, RST);
    cyc(0, 0, 0, IDLE, 0, NORM);
    cyc(5, 1, 5, LDUSE, 0, LU);
    cyc(5, 1, 5, 7'b1100101, 0, NORM);
    cyc(0, 0, 0, IDLE, 0, NORM);
    cyc(0, 0, 0, LDUSE, 0, NORM);
    cyc(3, 7, 7, LDUSE, 0, LU);
    cyc(3, 7, 7, 7'b1011001, 0, NORM);
    cyc(5, 0, 5, 7'b1101001, 0, NORM);
    cyc(0, 0, 0, BR, 0, FLUSH);
    cyc(0, 0, 0, IDLE, 0, FL2);
    cyc(0, 0, 0, IDLE, 0, NORM);
    repeat (4) cyc(0, 0, 0, MISS, 0, FRZ);
    cyc(0, 0, 0, HIT, 0, NORM);
    cyc(0, 0, 0, IDLE, 0, NORM);
    repeat (2) cyc(0, 0, 0, 7'b0000110, 0, FRZ);
    cyc(0, 0, 0, 7'b0000111, 0, FLUSH);
    cyc(0, 0, 0, IDLE, 0, FL2);
    cyc(0, 0, 0, IDLE, 0, NORM);
    cyc(5, 1, 5, 7'b1111011, 0, FLUSH);
    cyc(0, 0, 0, IDLE, 0, FL2);
    cyc(0, 0, 0, IDLE, 0, NORM);
    cyc(0, 0, 0, BR, 0, FLUSH);
    cyc(0, 0, 0, MISS, 0, FRZ);
    cyc(0, 0, 0, HIT, 0, NORM);
    cyc(0, 0, 0, IDLE, 0, NORM);
    cyc(0, 0, 0, BR, 0, FLUSH);
    rst_n = 1'b0;
    cyc(0, 0, 0, IDLE, 1, RST);
    rst_n = 1'b1;
    cyc(0, 0, 0, IDLE, 1, RST);
    cyc(0, 0, 0, IDLE, 0, NORM);
    cyc(0, 0, 0, MISS, 0, FRZ);
    rst_n = 1'b0;
    cyc(0, 0, 0, MISS, 1, RST);
    rst_n = 1'b1;
    cyc(0, 0, 0, IDLE, 1, RST);
    cyc(0, 0, 0, IDLE, 0, NORM);
    repeat (20) cyc(5, 1, 5, LDUSE, 0, LU);
    cyc(0, 0, 0, IDLE, 0, NORM);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule

// File: doc/ama_riscv_hazard_ctrl.md
# ama_riscv_hazard_ctrl

Pipeline hazard controller for the AMA-RISCV core. It covers the hazards that operand forwarding cannot resolve: load-use, taken branch/jump, and DMEM not-ready. For each it drives pipeline-register write enables and clears. It also keeps saturating stall and flush performance counters. It sits beside the ID-stage forwarding logic and consumes the same rs/rd/we signals.

## Interface
- CNT_W, 32, width of each performance counter
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rs1_id, rs2_id  in  5  ID-stage source registers
- rs1_used_id, rs2_used_id  in  1  ID instruction actually reads rs1/rs2
- rd_ex  in  5  EX-stage destination
- reg_we_ex  in  1  EX instruction writes RF
- load_inst_ex  in  1  EX instruction is a load
- load_inst_mem  in  1  MEM instruction is a load
- branch_taken_ex  in  1  branch taken or jump redirect resolved in EX
- dmem_ready  in  1  DMEM read data valid this cycle
- pc_we  out  1  PC update enable
- if_id_we  out  1  IF/ID register enable
- if_id_clear  out  1  IF/ID loaded with NOP
- id_ex_we  out  1  ID/EX register enable
- id_ex_clear  out  1  ID/EX loaded with NOP
- ex_mem_we  out  1  EX/MEM register enable
- stall_cnt  out  CNT_W  cycles with pc_we=0 outside reset states
- flush_cnt  out  CNT_W  number of taken-branch flush events

## Operation
- Conditions, evaluated combinationally each cycle:
  - load_use: load_inst_ex & reg_we_ex & rd_ex≠0 & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex))
  - mem_wait: load_inst_mem & !dmem_ready
- FSM states: RESET, RUN, FLUSH2, MEM_WAIT.
- RESET:
  - Entered asynchronously on rst_n=0.
  - Outputs: all enables 0; both clears 1.
  - Next state is RUN on the first clock edge with rst_n=1.
- RUN and FLUSH2, decisions in priority order:
  1. mem_wait: freeze. pc_we, if_id_we, id_ex_we and ex_mem_we are 0; clears are 0. Next state MEM_WAIT.
  2. branch_taken_ex: all enables 1; if_id_clear=1, id_ex_clear=1. Next state FLUSH2, because IMEM has 1-cycle read latency and one wrong-path fetch remains. flush_cnt increments.
  3. load_use: pc_we=0, if_id_we=0, id_ex_clear=1; id_ex_we=1 and ex_mem_we=1. Next state RUN. After this one bubble the load is in MEM and RF forwarding covers the dependency.
  4. Otherwise: all enables 1, clears 0.
- FLUSH2 additionally forces if_id_clear=1 unless mem_wait holds. Exit to RUN unless rule 1 or 2 applies.
- MEM_WAIT:
  - Holds the freeze outputs while dmem_ready=0.
  - When dmem_ready=1, outputs are the RUN result and the next state follows the RUN rules.
  - A branch_taken_ex that arrives during the freeze is held in EX and is acted on when the freeze releases.
- Counters:
  - Reset to 0 and saturate at all-ones.
  - stall_cnt increments in every non-RESET cycle with pc_we=0.
  - flush_cnt increments once per rule-2 cycle.

## Timing
- All outputs are combinational from state and inputs, with zero-cycle latency. Counters are registered and update one edge after the event.
- Reset values: pc_we=0, if_id_we=0, id_ex_we=0, ex_mem_we=0, if_id_clear=1, id_ex_clear=1, stall_cnt=0, flush_cnt=0.
- Load-use costs exactly 1 cycle; a taken branch costs 2 cycles (1 combinational flush plus FLUSH2); a DMEM miss costs N cycles while dmem_ready=0.
- Simultaneous events:
  - load_use and branch_taken_ex: the branch wins and the ID instruction is squashed.
  - mem_wait and branch_taken_ex: freeze first, then flush.
- rst_n asserted mid-stall or mid-flush returns immediately to RESET outputs. In-flight counts are cleared.

## Structure
- FSM state encodings, 2-bit (RESET=0, RUN=1, FLUSH2=2, MEM_WAIT=3), and the `RF_X0_ZERO` reuse belong in ama_riscv_defines.v.
- Sub-module ama_riscv_sat_counter (parameter W; inputs clk, rst_n, inc; output cnt) is instantiated twice.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release. Required: outputs at reset values, then pc_we=1 in the cycle after the first edge.
- Load-use: `lw x5` in EX, then `add x6,x5,x1` in ID. Required: exactly one cycle with pc_we=0 and id_ex_clear=1, and stall_cnt=1. The same case with rd_ex=x0 must give no stall.
- Taken branch at cycle T. Required: T has if_id_clear=1 and id_ex_clear=1; T+1 has if_id_clear=1; T+2 is normal; flush_cnt=1.
- DMEM miss: load in MEM with dmem_ready low for 4 cycles. Required: all enables 0 for 4 cycles, stall_cnt=4, then resume with no lost instruction.
- Branch_taken_ex during the DMEM freeze: flush occurs in the first cycle after dmem_ready=1. Load_use together with a branch: flush only, no extra bubble.
- Saturation with CNT_W=4: force 20 stall cycles. Required: stall_cnt holds at 15.
